regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the single write port and single read port of the 4x16 `register_file` among NUM_REQ requesters.
- Grants one transaction per cycle, either a read or a write, using a round-robin arbiter.
- Supports a lock so one requester can keep the port for back-to-back sequences.
- Returns read data registered, one cycle after the grant, tagged by a one-hot valid.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- DATA_WIDTH, 16, register width; must match `register_file`.
- INDEX_WIDTH, 2, register index width; 4 entries.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- req  input  NUM_REQ  per-requester transaction request, held until granted.
- req_we  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_lock  input  NUM_REQ  per-requester: keep ownership after this grant.
- req_index  input  NUM_REQ*INDEX_WIDTH  packed register index; requester i at slice [i*INDEX_WIDTH +: INDEX_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data; same slicing scheme.
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as acceptance.
- rvalid  output  NUM_REQ  one-hot, registered; read data is valid for this requester.
- rdata  output  DATA_WIDTH  registered read data, shared by all requesters.
- locked  output  1  registered; 1 while in the LOCKED state.
- rf_write_enable  output  1  to `register_file` write_enable.
- rf_write_index  output  INDEX_WIDTH  to `register_file` write_index.
- rf_write_data  output  DATA_WIDTH  to `register_file` write_data.
- rf_read_index  output  INDEX_WIDTH  to `register_file` read_index_a.
- rf_read_data  input  DATA_WIDTH  from `register_file` read_data_a; combinational read of current contents.

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, priority pointer=0, rvalid=0, rdata=0, locked=0.
  - While reset=1, gnt=0 and rf_write_enable=0 regardless of req.
- Arbitration in IDLE:
  - Grant the first requester with req=1, searching circularly from the pointer (pointer, pointer+1, ... mod NUM_REQ).
  - At most one gnt bit is set.
  - If no requester has req=1, gnt=0.
- Arbitration in LOCKED(owner):
  - Only the owner can be granted; other requests wait, gnt=0 for them.
- Grant effects, same cycle, for granted requester g:
  - rf_write_enable=req_we[g].
  - rf_write_index=index[g], rf_write_data=wdata[g].
  - rf_read_index=index[g].
- With no grant:
  - rf_write_enable=0, rf_write_index=0, rf_write_data=0, rf_read_index=0.
- Write latency: the register updates at the posedge ending the grant cycle.
- Read latency: on a granted read at posedge, rdata<=rf_read_data and rvalid<=onehot(g), so data appears the cycle after the grant.
  - rvalid is a one-cycle pulse.
  - rdata holds its value until the next granted read or reset.
- Back-to-back reads pipeline at one per cycle.
- Read-after-write to the same index on consecutive grants returns the new data, because the write commits before the read cycle.
- Pointer update: on any grant to g with req_lock[g]=0, pointer<=(g+1) mod NUM_REQ.
  - On a grant with lock=1, the pointer is unchanged.
- State transitions:
  - IDLE -> LOCKED(g): granted with req_lock[g]=1.
  - LOCKED -> LOCKED: owner granted with lock=1.
  - LOCKED -> IDLE: owner granted with lock=0 (the final transaction is still performed); pointer<=owner+1.
  - LOCKED -> IDLE: owner has req=0 in any cycle; no grant that cycle; pointer<=owner+1.
- Reset mid-operation:
  - Aborts a lock; state=IDLE.
  - Any read granted in the reset cycle is dropped, so rvalid=0 next cycle.
  - No write is issued during reset.
- Requester handshake: inputs must stay stable while req=1 and gnt=0. A requester deasserts req, or presents its next op, in the cycle after gnt.

Test Plan:
1. Reset then idle: reset for 1 cycle with req=0 -> gnt=0, rvalid=0, rdata=0, locked=0, rf_write_enable=0.
2. Write then read: req0 writes 16'hBEEF to index 2; the next cycle req0 reads index 2 -> gnt=01 both cycles, then rvalid=01 and rdata=16'hBEEF in the third cycle.
3. Round-robin: req=11 held for 4 cycles, all reads -> gnt sequence 01,10,01,10; each rvalid follows its grant by one cycle.
4. Lock: req1 writes index 0..2 with lock=1,1,0 while req0 is held -> gnt=10 for 3 cycles, locked=1 after the first two grants, then gnt=01 in cycle 4.
5. Lock release by drop: after req1 locks, req1=0 for one cycle -> no grant that cycle, locked=0 next, req0 granted the following cycle.
6. Reset during lock and read: reset asserted in a cycle where owner req1 reads -> gnt=0, rvalid=0 next, locked=0, pointer=0 (req0 wins a tie afterwards).

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin arbiter sharing one register_file port pair among requesters
//
// Purpose: grants at most one read or write per cycle to one of NUM_REQ
// requesters, drives the register_file write and read ports from the granted
// requester, and returns read data registered one cycle after the grant.
// A requester may lock the port across back-to-back transactions.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req/req_we/req_lock  per-requester request, op (1=write), keep-ownership
//   req_index/req_wdata  packed per-requester index and write data
//   gnt               one-hot combinational grant
//   rvalid/rdata      registered one-hot read valid and shared read data
//   locked            registered, high while a requester owns the port
//   rf_*              register_file write port and read port A

module regfile_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           locked,
    output logic                           rf_write_enable,
    output logic [INDEX_WIDTH-1:0]         rf_write_index,
    output logic [DATA_WIDTH-1:0]          rf_write_data,
    output logic [INDEX_WIDTH-1:0]         rf_read_index,
    input  logic [DATA_WIDTH-1:0]          rf_read_data
);

    localparam int SEL_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] cand;
    logic             any_gnt;

    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
        if (s == SEL_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return s + SEL_W'(1);
    endfunction

    // Grant selection: the owner alone while locked, otherwise the first
    // requester found scanning circularly from the priority pointer.
    always_comb begin
        gnt     = '0;
        gidx    = '0;
        cand    = '0;
        any_gnt = 1'b0;
        if (!reset) begin
            if (state == LOCKED) begin
                if (req[owner]) begin
                    any_gnt = 1'b1;
                    gidx    = owner;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = SEL_W'((int'(ptr) + k) % NUM_REQ);
                    if (!any_gnt && req[cand]) begin
                        any_gnt = 1'b1;
                        gidx    = cand;
                    end
                end
            end
            if (any_gnt) begin
                gnt[gidx] = 1'b1;
            end
        end
    end

    // Port steering: idle ports are driven to zero so the register_file
    // sees a quiet bus when nobody is granted.
    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_index  = '0;
        rf_write_data   = '0;
        rf_read_index   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rf_write_enable = req_we[i];
                rf_write_index  = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                rf_write_data   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                rf_read_index   = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            rvalid <= '0;
            rdata  <= '0;
            locked <= 1'b0;
        end else begin
            rvalid <= '0;
            if (any_gnt) begin
                if (!req_we[gidx]) begin
                    rvalid <= gnt;
                    rdata  <= rf_read_data;
                end
                if (req_lock[gidx]) begin
                    // Pointer stays put while a lock is held or taken.
                    state  <= LOCKED;
                    owner  <= gidx;
                    locked <= 1'b1;
                end else begin
                    state  <= IDLE;
                    ptr    <= next_sel(gidx);
                    locked <= 1'b0;
                end
            end else if (state == LOCKED) begin
                // Owner dropped its request: release without a grant.
                state  <= IDLE;
                ptr    <= next_sel(owner);
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - scoreboard bench for regfile_port_arbiter with a register_file model

module tb_regfile_port_arbiter;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       req = '0;
    logic [N-1:0]       req_we = '0;
    logic [N-1:0]       req_lock = '0;
    logic [N*IW-1:0]    req_index = '0;
    logic [N*DW-1:0]    req_wdata = '0;
    logic [N-1:0]       gnt;
    logic [N-1:0]       rvalid;
    logic [DW-1:0]      rdata;
    logic               locked;
    logic               rf_write_enable;
    logic [IW-1:0]      rf_write_index;
    logic [DW-1:0]      rf_write_data;
    logic [IW-1:0]      rf_read_index;
    logic [DW-1:0]      rf_read_data;

    regfile_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_index(req_index), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .locked(locked), .rf_write_enable(rf_write_enable),
        .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
        .rf_read_index(rf_read_index), .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Environment register file: cleared on reset so the model can track it.
    logic [DW-1:0] rf_mem [4];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
        end else if (rf_write_enable) begin
            rf_mem[rf_write_index] <= rf_write_data;
        end
    end
    assign rf_read_data = rf_mem[rf_read_index];

    // Pending operation per requester.
    logic          p_req  [N];
    logic          p_we   [N];
    logic          p_lock [N];
    logic [IW-1:0] p_idx  [N];
    logic [DW-1:0] p_wd   [N];

    // Reference model: pointer, owner (-1 = unlocked), register contents.
    int            m_ptr = 0;
    int            m_owner = -1;
    logic [DW-1:0] m_mem [4];
    int            last_gnt = -1;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
    } rd_t;
    rd_t rq [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic we, input logic lk,
                          input logic [IW-1:0] idx, input logic [DW-1:0] wd);
        p_req[i]  = 1'b1;
        p_we[i]   = we;
        p_lock[i] = lk;
        p_idx[i]  = idx;
        p_wd[i]   = wd;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]              = p_req[i];
            req_we[i]           = p_we[i];
            req_lock[i]         = p_lock[i];
            req_index[i*IW +: IW] = p_idx[i];
            req_wdata[i*DW +: DW] = p_wd[i];
        end
    endtask

    // One clock cycle: apply inputs, compare combinational outputs with the
    // model's choice, then advance the model as the posedge will.
    task automatic cycle(input logic rst);
        int            g;
        int            c;
        logic [31:0]   eg;
        logic          ewe;
        logic [IW-1:0] eidx;
        logic [DW-1:0] ewd;
        @(negedge clk);
        reset = rst;
        drive();
        #1;
        g = -1;
        if (!rst) begin
            if (m_owner >= 0) begin
                if (p_req[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && p_req[c]) g = c;
                end
            end
        end
        eg   = (g >= 0) ? (32'd1 << g) : 32'd0;
        ewe  = 1'b0;
        eidx = '0;
        ewd  = '0;
        if (g >= 0) begin
            ewe  = p_we[g];
            eidx = p_idx[g];
            ewd  = p_wd[g];
        end
        check("gnt", 32'(gnt), eg);
        check("locked", 32'(locked), 32'(m_owner >= 0));
        check("rf_write_enable", 32'(rf_write_enable), 32'(ewe));
        check("rf_write_index", 32'(rf_write_index), 32'(eidx));
        check("rf_write_data", 32'(rf_write_data), 32'(ewd));
        check("rf_read_index", 32'(rf_read_index), 32'(eidx));
        if (rst) begin
            m_ptr   = 0;
            m_owner = -1;
            for (int i = 0; i < 4; i++) m_mem[i] = '0;
        end else if (g >= 0) begin
            if (!p_we[g]) rq.push_back('{who: g, data: m_mem[p_idx[g]]});
            else m_mem[p_idx[g]] = p_wd[g];
            if (p_lock[g]) begin
                m_owner = g;
            end else begin
                m_owner = -1;
                m_ptr   = (g + 1) % N;
            end
        end else if (m_owner >= 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
        last_gnt = g;
    endtask

    task automatic run_until(input int i);
        int t;
        t = 0;
        cycle(1'b0);
        while (last_gnt != i && t < 8) begin
            cycle(1'b0);
            t++;
        end
        check("grant_wait", 32'(last_gnt), 32'(i));
    endtask

    // Monitor: every cycle pops the read expected to complete at this edge.
    logic [DW-1:0] exp_rdata = '0;
    logic          was_rst;
    initial begin
        rd_t e;
        forever begin
            @(posedge clk);
            was_rst = reset;
            @(negedge clk);
            if (was_rst) exp_rdata = '0;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                check("rvalid", 32'(rvalid), 32'd1 << e.who);
                exp_rdata = e.data;
            end else begin
                check("rvalid_idle", 32'(rvalid), 32'd0);
            end
            check("rdata", 32'(rdata), 32'(exp_rdata));
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_lock[i] = 1'b0; p_idx[i] = '0; p_wd[i] = '0;
        end
        for (int i = 0; i < 4; i++) m_mem[i] = '0;

        // Reset then idle.
        cycle(1'b1);
        cycle(1'b0);

        // Write then read the same index.
        set_op(0, 1'b1, 1'b0, 2'd2, 16'hBEEF);
        cycle(1'b0);
        set_op(0, 1'b0, 1'b0, 2'd2, 16'h0000);
        cycle(1'b0);
        p_req[0] = 1'b0;
        cycle(1'b0);
        check("raw_rdata", 32'(rdata), 32'h0000BEEF);

        // Round-robin between two held reads.
        set_op(0, 1'b0, 1'b0, 2'd1, 16'h0);
        set_op(1, 1'b0, 1'b0, 2'd2, 16'h0);
        repeat (4) cycle(1'b0);
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        cycle(1'b0);

        // Locked write burst from req1 while req0 waits.
        set_op(1, 1'b1, 1'b1, 2'd0, 16'h1000);
        cycle(1'b0);
        set_op(0, 1'b0, 1'b0, 2'd3, 16'h0);
        for (int w = 1; w < 3; w++) begin
            set_op(1, 1'b1, (w < 2), 2'(w), 16'(16'h1000 + w));
            run_until(1);
        end
        p_req[1] = 1'b0;
        run_until(0);
        p_req[0] = 1'b0;

        // Lock released by the owner dropping req.
        set_op(1, 1'b1, 1'b1, 2'd3, 16'h5555);
        run_until(1);
        p_req[1] = 1'b0;
        set_op(0, 1'b0, 1'b0, 2'd3, 16'h0);
        cycle(1'b0);
        check("drop_no_grant", 32'(gnt), 32'd0);
        run_until(0);
        p_req[0] = 1'b0;

        // Reset while the owner presents a read.
        set_op(1, 1'b0, 1'b1, 2'd1, 16'h0);
        run_until(1);
        set_op(1, 1'b0, 1'b1, 2'd2, 16'h0);
        set_op(0, 1'b0, 1'b0, 2'd0, 16'h0);
        cycle(1'b1);
        cycle(1'b0);
        check("tie_after_reset", 32'(gnt), 32'd1);
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        cycle(1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i || !p_req[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_op(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                               2'($urandom_range(0, 3)), 16'($urandom));
                    else
                        p_req[i] = 1'b0;
                end
            end
            cycle($urandom_range(0, 59) == 0);
        end

        for (int i = 0; i < N; i++) p_req[i] = 1'b0;
        repeat (3) cycle(1'b0);
        check("queue_drained", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
